clk_switch_ctrl: RTL and testbench
==================================

// Module: clk_switch_ctrl
// PURPOSE
//  Sequencer for the two-source glitch-free clock mux. Runs on an always-on reference clock,
//  accepts source-change requests, powers up the target source, waits for it to report stable,
//  then flips the mux select and waits for handover. Optionally gates off the old source after.
//  Reports completion or timeout to the power/clock manager.
// PARAMETERS
//  STABLE_TIMEOUT  1024  max ref cycles in ENABLE waiting for target stable before error
//  SETTLE_CYCLES   8     ref cycles held in SWITCH after select flips (mux handover time)
//  CNT_W           11    counter width; must hold max(STABLE_TIMEOUT, SETTLE_CYCLES)
//  GATE_OLD        1     1: deassert old source enable after switch; 0: leave both enabled
// PORTS
//  clk         in   1  always-on reference clock; all logic on posedge clk
//  rst_n       in   1  asynchronous active-low reset
//  req_valid   in   1  switch request valid
//  req_src     in   1  requested source (0 = clk0, 1 = clk1)
//  req_ready   out  1  high only in IDLE; request accepted when req_valid & req_ready
//  src_stable  in   2  per-source stable/lock flags, asynchronous; 2-flop synchronised inside
//  src_en      out  2  per-source enable to oscillator/PLL
//  select      out  1  mux select (0 = clk0, 1 = clk1)
//  cur_src     out  1  source currently driving the mux
//  busy        out  1  high in any state other than IDLE
//  done        out  1  1-cycle pulse: request completed
//  err         out  1  1-cycle pulse: target source timed out, request abandoned
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): state=IDLE, select=0, cur_src=0, src_en=2'b01,
//   counter=0, done=0, err=0, sync flops=0. No handover is completed on reset.
//  FSM states: IDLE, ENABLE, SWITCH, GATE, DONE, ERR. Target latched at accept (tgt).
//  IDLE: req_ready=1. Accept at cycle T:
//   - req_src==cur_src: -> DONE; done pulses at T+1; select/src_en unchanged.
//   - else: -> ENABLE; src_en[tgt]=1 from T+1; counter cleared.
//  ENABLE: counter increments each cycle. Synced src_stable[tgt]==1 -> SWITCH (stable
//   takes priority over timeout in the same cycle). Counter reaches STABLE_TIMEOUT-1
//   with stable low -> ERR.
//  SWITCH: select=tgt from first SWITCH cycle; counter reloaded with 0, counts
//   SETTLE_CYCLES cycles, then cur_src=tgt and -> GATE (GATE_OLD=1) or DONE (GATE_OLD=0).
//  GATE: src_en[~tgt]=0 for one cycle entry, -> DONE.
//  DONE: done=1 for exactly one cycle, -> IDLE.
//  ERR: src_en[tgt]=0 (cur_src enable untouched), err=1 for one cycle, -> IDLE.
//  src_en[cur_src] is never deasserted outside reset; select only changes on SWITCH entry.
//  req_valid while busy: ignored, not queued; requester must hold until req_ready.
//  Source stable dropping during SWITCH/GATE: no effect (status only sampled in ENABLE).
//  Counter saturates at all-ones; never wraps.
// TESTING
//  1 Reset: rst_n low mid-cycle -> select=0, src_en=01, cur_src=0, busy=0, req_ready=1 at once.
//  2 Normal switch: req_src=1, src_stable[1] rises 5 cycles after accept -> src_en=11,
//    select=1 ~2 cycles after rise (sync), done after 8 settle cycles + GATE, final src_en=10.
//  3 Same-source: cur_src=0, req_src=0 -> done at T+1, busy 1 cycle, no select/src_en change.
//  4 Timeout: req_src=1, src_stable held 00 -> err after 1024 ENABLE cycles, src_en back to 01,
//    select stays 0, no done.
//  5 Busy request: second req_valid during ENABLE -> not accepted, req_ready=0, first completes.
//  6 Reset in SWITCH (select just flipped to 1) -> immediate select=0, src_en=01, state IDLE;
//    then GATE_OLD=0 build: switch 0->1 ends with src_en=11.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a two-source glitch-free clock mux, clocked by the always-on reference clock.
// Handles enabling the target source, waiting for it to be stable, handing over the mux select and gating the old source.
module clk_switch_ctrl #(
    parameter int unsigned STABLE_TIMEOUT = 1024,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned CNT_W          = 11,
    parameter int unsigned GATE_OLD       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_src,
    output logic       req_ready,
    input  logic [1:0] src_stable,
    output logic [1:0] src_en,
    output logic       select,
    output logic       cur_src,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENABLE = 3'd1;
    localparam logic [2:0] ST_SWITCH = 3'd2;
    localparam logic [2:0] ST_GATE   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STABLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             tgt;
    logic             other;
    logic [1:0]       stable_meta;
    logic [1:0]       stable_sync;

    // The stable flags come from other clock domains, so they pass through two flops first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_meta <= '0;
            stable_sync <= '0;
        end else begin
            stable_meta <= src_stable;
            stable_sync <= stable_meta;
        end
    end

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign other   = ~tgt;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = (req_src == cur_src) ? ST_DONE : ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                // A stable report wins over a timeout seen in the same cycle.
                if (stable_sync[tgt]) begin
                    state_next = ST_SWITCH;
                end else if (cnt >= TIMEOUT_LAST) begin
                    state_next = ST_ERR;
                end
            end
            ST_SWITCH: begin
                if (cnt >= SETTLE_LAST) begin
                    state_next = (GATE_OLD != 0) ? ST_GATE : ST_DONE;
                end
            end
            ST_GATE:  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tgt     <= 1'b0;
            select  <= 1'b0;
            cur_src <= 1'b0;
            src_en  <= 2'b01;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        tgt <= req_src;
                        cnt <= '0;
                        if (req_src != cur_src) begin
                            src_en[req_src] <= 1'b1;
                        end
                    end
                end
                ST_ENABLE: begin
                    if (state_next == ST_SWITCH) begin
                        select <= tgt;
                        cnt    <= '0;
                    end else if (state_next == ST_ERR) begin
                        src_en[tgt] <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_SWITCH: begin
                    // Handover is complete once the settle window has elapsed.
                    if (state_next != ST_SWITCH) begin
                        cur_src <= tgt;
                        if (state_next == ST_GATE) begin
                            src_en[other] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed and random switch requests checked against an edge-count model.
// One instance uses default parameters; a second uses a short timeout and leaves the old source enabled.
module tb_clk_switch_ctrl;

    localparam int TMO0  = 1024;
    localparam int SET0  = 8;
    localparam int GAT0  = 1;
    localparam int TMO1  = 64;
    localparam int SET1  = 4;
    localparam int GAT1  = 0;
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_src = '0;
    logic [1:0] stable [2];
    logic [1:0] en [2];
    logic [1:0] req_ready, select, cur_src, busy, done, err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model state: which source drives the mux and which enables are up, per instance.
    logic       m_cur [2];
    logic [1:0] m_en [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_switch_ctrl #(
        .STABLE_TIMEOUT(TMO0),
        .SETTLE_CYCLES (SET0),
        .CNT_W         (11),
        .GATE_OLD      (GAT0)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_src   (req_src[0]),
        .req_ready (req_ready[0]),
        .src_stable(stable[0]),
        .src_en    (en[0]),
        .select    (select[0]),
        .cur_src   (cur_src[0]),
        .busy      (busy[0]),
        .done      (done[0]),
        .err       (err[0])
    );

    clk_switch_ctrl #(
        .STABLE_TIMEOUT(TMO1),
        .SETTLE_CYCLES (SET1),
        .CNT_W         (7),
        .GATE_OLD      (GAT1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_src   (req_src[1]),
        .req_ready (req_ready[1]),
        .src_stable(stable[1]),
        .src_en    (en[1]),
        .select    (select[1]),
        .cur_src   (cur_src[1]),
        .busy      (busy[1]),
        .done      (done[1]),
        .err       (err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and checks that outputs respond without waiting for a clock edge.
    task automatic do_reset(input int u);
        #2 rst_n = 1'b0;
        req_valid = '0;
        stable[0] = 2'b01;
        stable[1] = 2'b01;
        #1;
        check("rst_select", 32'(select[u]), 32'd0);
        check("rst_src_en", 32'(en[u]), 32'd1);
        check("rst_cur_src", 32'(cur_src[u]), 32'd0);
        check("rst_busy", 32'(busy[u]), 32'd0);
        check("rst_ready", 32'(req_ready[u]), 32'd1);
        check("rst_done", 32'(done[u]), 32'd0);
        check("rst_err", 32'(err[u]), 32'd0);
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 1'b0;
            m_en[k]  = 2'b01;
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    // One request. d = cycles after accept at which the target reports stable.
    // rst_off >= 0 asserts reset that many cycles after select flips.
    task automatic run_txn(input int u, input logic src, input int d, input bit busy_req,
                           input bit drop, input int rst_off);
        int tmo, st, a, s_edge, done_e, err_e, idle_e;
        bit gate, pre, stop;
        logic old, tgt, exp_sel, exp_cur, exp_busy;
        logic [1:0] exp_en;
        tmo  = (u == 0) ? TMO0 : TMO1;
        st   = (u == 0) ? SET0 : SET1;
        gate = (u == 0) ? (GAT0 != 0) : (GAT1 != 0);
        old  = m_cur[u];
        tgt  = src;
        pre  = stable[u][tgt];
        exp_en = m_en[u];
        check("ready_before_req", 32'(req_ready[u]), 32'd1);
        req_src[u]   = src;
        req_valid[u] = 1'b1;
        tick();
        req_valid[u] = 1'b0;
        a = cyc;
        s_edge = -1;
        done_e = -1;
        err_e  = -1;
        if (tgt == old) begin
            done_e = a;
            idle_e = a + 1;
        end else begin
            // Stable is seen three edges after it rises (two sync flops, then the FSM).
            s_edge = pre ? a + 1 : a + d + 3;
            if (s_edge <= a + tmo) begin
                done_e = s_edge + st + (gate ? 1 : 0);
                idle_e = done_e + 1;
            end else begin
                s_edge = -1;
                err_e  = a + tmo;
                idle_e = err_e + 1;
            end
        end
        stop = 1'b0;
        while (!stop && cyc <= idle_e) begin
            if (tgt != old && !pre && cyc == a + d) stable[u][tgt] = 1'b1;
            if (drop && s_edge >= 0 && cyc == s_edge + 1) stable[u][tgt] = 1'b0;
            if (drop && s_edge >= 0 && cyc == s_edge + 4) stable[u][tgt] = 1'b1;
            if (busy_req) begin
                req_src[u]   = ~src;
                req_valid[u] = (cyc >= a + 2 && cyc <= a + 5);
            end
            exp_sel = (s_edge >= 0 && cyc >= s_edge) ? tgt : old;
            exp_cur = (s_edge >= 0 && cyc >= s_edge + st) ? tgt : old;
            exp_en  = m_en[u];
            if (tgt != old) exp_en[tgt] = 1'b1;
            if (err_e >= 0 && cyc >= err_e) exp_en[tgt] = 1'b0;
            if (s_edge >= 0 && gate && cyc >= s_edge + st) exp_en[old] = 1'b0;
            exp_busy = (cyc < idle_e);
            check("select", 32'(select[u]), 32'(exp_sel));
            check("cur_src", 32'(cur_src[u]), 32'(exp_cur));
            check("src_en", 32'(en[u]), 32'(exp_en));
            check("busy", 32'(busy[u]), 32'(exp_busy));
            check("req_ready", 32'(req_ready[u]), 32'(!exp_busy));
            check("done", 32'(done[u]), 32'(cyc == done_e));
            check("err", 32'(err[u]), 32'(cyc == err_e));
            if (rst_off >= 0 && s_edge >= 0 && cyc == s_edge + rst_off) begin
                do_reset(u);
                stop = 1'b1;
            end else begin
                tick();
            end
        end
        if (!stop) begin
            req_valid[u] = 1'b0;
            m_cur[u] = exp_cur;
            m_en[u]  = exp_en;
            if (s_edge >= 0 && gate) stable[u][old] = 1'b0;
            if (err_e >= 0) stable[u][tgt] = 1'b0;
            repeat (3) tick();
        end
    endtask

    initial begin
        stable[0] = 2'b01;
        stable[1] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 1'b0;
            m_en[k]  = 2'b01;
        end
        tick();
        tick();
        do_reset(0);

        run_txn(0, 1'b0, 0, 1'b0, 1'b0, -1);
        run_txn(0, 1'b1, 5, 1'b1, 1'b0, -1);
        run_txn(0, 1'b1, 0, 1'b0, 1'b0, -1);
        run_txn(0, 1'b0, 2, 1'b0, 1'b1, -1);
        run_txn(0, 1'b1, NEVER, 1'b0, 1'b0, -1);
        run_txn(0, 1'b1, TMO0 - 3, 1'b0, 1'b0, -1);
        run_txn(0, 1'b0, 0, 1'b0, 1'b0, -1);
        run_txn(0, 1'b1, TMO0 - 2, 1'b0, 1'b0, -1);
        repeat (10) begin
            run_txn(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        if (m_cur[0] != 1'b0) run_txn(0, 1'b0, 1, 1'b0, 1'b0, -1);
        run_txn(0, 1'b1, 3, 1'b0, 1'b0, 0);
        run_txn(0, 1'b0, 0, 1'b0, 1'b0, -1);

        do_reset(1);
        run_txn(1, 1'b1, NEVER, 1'b0, 1'b0, -1);
        run_txn(1, 1'b1, TMO1 - 3, 1'b0, 1'b0, -1);
        run_txn(1, 1'b0, 7, 1'b1, 1'b0, -1);
        repeat (6) begin
            run_txn(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
